// File: rtl/prn_epoch_sequencer_if.sv
// Host/generator-side signal bundle for the PRN epoch sequencer.
// The host drives the master modport; the sequencer sits on the slave modport.
interface prn_epoch_sequencer_if #(
    parameter int CNT_W = 14
);
    logic             seed_wr;
    logic [3:0]       seed_addr;
    logic [7:0]       seed_byte;
    logic             start;
    logic             stop;
    logic             chip_tick;
    logic             gen_load_en;
    logic             gen_load_data;
    logic             gen_adv;
    logic [CNT_W-1:0] chip_idx;
    logic             epoch_pulse;
    logic [7:0]       epoch_count;
    logic             busy;
    logic             overrun;

    modport master (
        output seed_wr, seed_addr, seed_byte, start, stop, chip_tick,
        input  gen_load_en, gen_load_data, gen_adv, chip_idx,
               epoch_pulse, epoch_count, busy, overrun
    );

    modport slave (
        input  seed_wr, seed_addr, seed_byte, start, stop, chip_tick,
        output gen_load_en, gen_load_data, gen_adv, chip_idx,
               epoch_pulse, epoch_count, busy, overrun
    );
endinterface

// File: rtl/prn_epoch_sequencer.sv
// Seeds the JNAV PRN generator serially from a double-buffered 115-bit seed,
// then advances it one chip per chip_tick, reseeding at each epoch boundary.
module prn_epoch_sequencer #(
    parameter int CODE_LEN = 10230,
    parameter int CNT_W    = 14,
    parameter bit RESEED   = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    prn_epoch_sequencer_if.slave bus
);

    localparam int               SEED_W   = 115;
    localparam logic [6:0]       LAST_BIT = 7'(SEED_W - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  chip_idx_q, chip_idx_d;
    logic [7:0]        epoch_cnt_q, epoch_cnt_d;
    logic              overrun_q, overrun_d;
    logic [SEED_W-1:0] shadow_q, shadow_d;
    logic [SEED_W-1:0] active_q, active_d;

    logic gen_adv;
    logic last_chip;
    logic epoch_hit;

    // Byte n lands on bits [8n+7:8n]; the top byte only keeps its low 3 bits.
    function automatic logic [SEED_W-1:0] write_byte(input logic [SEED_W-1:0] seed,
                                                     input logic [3:0]        addr,
                                                     input logic [7:0]        data);
        logic [119:0] wide;
        wide = {5'b0, seed};
        wide[{addr, 3'b000} +: 8] = data;
        return wide[SEED_W-1:0];
    endfunction

    always_comb begin
        gen_adv   = (state_q == S_RUN) && bus.chip_tick;
        last_chip = (chip_idx_q == LAST_IDX);
        epoch_hit = gen_adv && last_chip;
    end

    assign bus.gen_load_en   = (state_q == S_LOAD);
    assign bus.gen_load_data = (state_q == S_LOAD) && active_q[LAST_BIT - bit_cnt_q];
    assign bus.gen_adv       = gen_adv;
    assign bus.epoch_pulse   = epoch_hit;
    assign bus.chip_idx      = chip_idx_q;
    assign bus.epoch_count   = epoch_cnt_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.overrun       = overrun_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        chip_idx_d  = chip_idx_q;
        epoch_cnt_d = epoch_cnt_q;
        overrun_d   = overrun_q;
        shadow_d    = shadow_q;
        active_d    = active_q;

        if (bus.seed_wr && (bus.seed_addr != 4'hF)) begin
            shadow_d = write_byte(shadow_q, bus.seed_addr, bus.seed_byte);
        end

        // stop outranks everything, including a simultaneous start or epoch wrap
        if (bus.stop) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            chip_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d     = S_LOAD;
                        bit_cnt_d   = '0;
                        chip_idx_d  = '0;
                        epoch_cnt_d = '0;
                        overrun_d   = 1'b0;
                        active_d    = shadow_q;
                    end
                end
                S_LOAD: begin
                    if (bus.chip_tick) begin
                        overrun_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = S_RUN;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                S_RUN: begin
                    if (gen_adv) begin
                        if (last_chip) begin
                            chip_idx_d  = '0;
                            epoch_cnt_d = epoch_cnt_q + 8'd1;
                            if (RESEED) begin
                                state_d   = S_LOAD;
                                bit_cnt_d = '0;
                                active_d  = shadow_q;
                            end
                        end else begin
                            chip_idx_d = chip_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            chip_idx_q  <= '0;
            epoch_cnt_q <= '0;
            overrun_q   <= 1'b0;
            shadow_q    <= '0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            chip_idx_q  <= chip_idx_d;
            epoch_cnt_q <= epoch_cnt_d;
            overrun_q   <= overrun_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: tb/tb_prn_epoch_sequencer.sv
// Directed bench: two sequencers, CODE_LEN=4 with reseed and CODE_LEN=3 free-running.
module tb_prn_epoch_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prn_epoch_sequencer_if #(.CNT_W(14)) a ();
    prn_epoch_sequencer_if #(.CNT_W(14)) b ();

    prn_epoch_sequencer #(.CODE_LEN(4), .CNT_W(14), .RESEED(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    prn_epoch_sequencer #(.CODE_LEN(3), .CNT_W(14), .RESEED(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic st, input logic sp, input logic tk);
        @(negedge clk);
        a.start     = st;
        a.stop      = sp;
        a.chip_tick = tk;
        a.seed_wr   = 1'b0;
        #1;
    endtask

    task automatic cycb(input logic st, input logic sp, input logic tk);
        @(negedge clk);
        b.start     = st;
        b.stop      = sp;
        b.chip_tick = tk;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_after(input int gap);
        idle(gap - 1);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        a.seed_wr   = 1'b1;
        a.seed_addr = addr;
        a.seed_byte = data;
        a.start     = 1'b0;
        a.stop      = 1'b0;
        a.chip_tick = 1'b0;
        #1;
    endtask

    // Entered on the first LOAD cycle; leaves on the first cycle after LOAD.
    task automatic load_capture(output int n, output logic [114:0] bits, output logic clash);
        n     = 0;
        bits  = '0;
        clash = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!a.gen_load_en) break;
            if (a.gen_adv) clash = 1'b1;
            bits = {bits[113:0], a.gen_load_data};
            n++;
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [114:0] seed_of(input logic [7:0] base, input logic [7:0] top);
        logic [119:0] w;
        w = '0;
        for (int n = 0; n < 14; n++) w[8*n +: 8] = base + 8'(n);
        w[119:112] = top;
        return w[114:0];
    endfunction

    logic [114:0] exp0, exp1, bits;
    int           n, advs, loads_after;
    logic         clash;

    initial begin
        a.seed_wr = 0; a.seed_addr = 0; a.seed_byte = 0; a.start = 0; a.stop = 0; a.chip_tick = 0;
        b.seed_wr = 0; b.seed_addr = 0; b.seed_byte = 0; b.start = 0; b.stop = 0; b.chip_tick = 0;
        exp0 = seed_of(8'h00, 8'h0E);
        exp1 = seed_of(8'hA0, 8'hFF);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_load_en",   a.gen_load_en,   1'b0);
        chk("rst_load_data", a.gen_load_data, 1'b0);
        chk("rst_adv",       a.gen_adv,       1'b0);
        chk("rst_chip_idx",  a.chip_idx,      14'd0);
        chk("rst_pulse",     a.epoch_pulse,   1'b0);
        chk("rst_epoch",     a.epoch_count,   8'd0);
        chk("rst_busy",      a.busy,          1'b0);
        chk("rst_overrun",   a.overrun,       1'b0);
        rst_n = 1'b1;

        // Load order: bytes 0..14 = 0x00..0x0E, plus an ignored write to address 15
        for (int k = 0; k < 15; k++) wr(4'(k), 8'(k));
        wr(4'hF, 8'hFF);
        cyc(1'b1, 1'b0, 1'b0);
        chk("start_busy_lag", a.busy, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("load_busy", a.busy, 1'b1);
        load_capture(n, bits, clash);
        chk("load_len",   n,         115);
        chk("load_bits",  bits,      exp0);
        chk("load_msb",   bits[114], 1'b1);
        chk("load_clash", clash,     1'b0);
        chk("run_busy",   a.busy,    1'b1);
        chk("run_adv",    a.gen_adv, 1'b0);
        idle(5);
        chk("run_adv_notick", a.gen_adv,     1'b0);
        chk("run_no_load",    a.gen_load_en, 1'b0);

        // Epoch wrap with CODE_LEN=4
        for (int i = 1; i <= 4; i++) begin
            tick_after(200);
            chk($sformatf("ep_adv%0d", i),    a.gen_adv,     1'b1);
            chk($sformatf("ep_idx_at%0d", i), a.chip_idx,    14'(i - 1));
            chk($sformatf("ep_pulse%0d", i),  a.epoch_pulse, (i == 4));
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("ep_idx_after%0d", i), a.chip_idx, 14'(i % 4));
        end
        chk("ep_count",        a.epoch_count, 8'd1);
        chk("ep_pulse_single", a.epoch_pulse, 1'b0);
        load_capture(n, bits, clash);
        chk("reseed_len",  n,    115);
        chk("reseed_bits", bits, exp0);
        tick_after(200);
        chk("resume_adv", a.gen_adv,  1'b1);
        chk("resume_idx", a.chip_idx, 14'd0);
        chk("ep_overrun", a.overrun,  1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        tick_after(200);
        cyc(1'b0, 1'b0, 1'b0);
        chk("pre_stop_idx", a.chip_idx, 14'd2);

        // Stop mid-RUN at chip_idx 2
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("stop_busy",    a.busy,        1'b0);
        chk("stop_idx",     a.chip_idx,    14'd0);
        chk("stop_epoch",   a.epoch_count, 8'd1);
        chk("stop_load_en", a.gen_load_en, 1'b0);

        // start and stop together in IDLE
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("coll_busy",    a.busy,        1'b0);
        chk("coll_load_en", a.gen_load_en, 1'b0);
        chk("coll_epoch",   a.epoch_count, 8'd1);

        // Overrun: chip_tick every 50 cycles from start
        cyc(1'b1, 1'b0, 1'b0);
        advs  = 0;
        clash = 1'b0;
        for (int i = 0; i < 160; i++) begin
            cyc(1'b0, 1'b0, (i % 50) == 49);
            if (a.gen_adv) begin
                advs++;
                if (a.gen_load_en) clash = 1'b1;
            end
            if (i == 49) chk("ov_tick_in_load", a.gen_load_en, 1'b1);
            if (i == 50) begin
                chk("ov_set",           a.overrun,     1'b1);
                chk("ov_epoch_cleared", a.epoch_count, 8'd0);
            end
        end
        chk("ov_advs",   advs,       1);
        chk("ov_clash",  clash,      1'b0);
        chk("ov_sticky", a.overrun,  1'b1);
        chk("ov_idx",    a.chip_idx, 14'd1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ov_hold_stop", a.overrun, 1'b1);
        chk("ov_stop_busy", a.busy,    1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ov_clr_start", a.overrun, 1'b0);
        chk("ov_busy",      a.busy,    1'b1);
        load_capture(n, bits, clash);
        chk("ov_load_bits", bits, exp0);

        // Shadow update during RUN takes effect at the next reseed
        tick_after(200);
        cyc(1'b0, 1'b0, 1'b0);
        chk("sh_idx1", a.chip_idx, 14'd1);
        for (int k = 0; k < 14; k++) wr(4'(k), 8'hA0 + 8'(k));
        wr(4'd14, 8'hFF);
        wr(4'hF, 8'h5A);
        cyc(1'b0, 1'b0, 1'b0);
        chk("sh_no_load",  a.gen_load_en, 1'b0);
        chk("sh_idx_hold", a.chip_idx,    14'd1);
        for (int i = 2; i <= 4; i++) begin
            tick_after(200);
            cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("sh_idx%0d", i), a.chip_idx, 14'(i % 4));
        end
        chk("sh_epoch", a.epoch_count, 8'd1);
        load_capture(n, bits, clash);
        chk("sh_len",  n,    115);
        chk("sh_bits", bits, exp1);

        // Reset in the middle of a LOAD with epoch_count and overrun non-zero
        for (int i = 0; i < 4; i++) tick_after(200);
        cyc(1'b0, 1'b0, 1'b0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("pre_rst_load", a.gen_load_en, 1'b1);
        chk("pre_rst_ov",   a.overrun,     1'b1);
        chk("pre_rst_ep",   a.epoch_count, 8'd2);
        @(negedge clk);
        rst_n = 1'b0;
        a.chip_tick = 1'b1;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        a.chip_tick = 1'b0;
        #1;
        chk("mid_rst_load_en",   a.gen_load_en,   1'b0);
        chk("mid_rst_load_data", a.gen_load_data, 1'b0);
        chk("mid_rst_adv",       a.gen_adv,       1'b0);
        chk("mid_rst_idx",       a.chip_idx,      14'd0);
        chk("mid_rst_pulse",     a.epoch_pulse,   1'b0);
        chk("mid_rst_epoch",     a.epoch_count,   8'd0);
        chk("mid_rst_busy",      a.busy,          1'b0);
        chk("mid_rst_ov",        a.overrun,       1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        load_capture(n, bits, clash);
        chk("post_rst_len",  n,    115);
        chk("post_rst_bits", bits, 115'd0);

        // Free-running instance: one load, then epochs every 3 chips
        cycb(1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 130; i++) begin
            cycb(1'b0, 1'b0, 1'b0);
            if (b.gen_load_en) n++;
        end
        chk("b_load_len", n, 115);
        loads_after = 0;
        for (int j = 1; j <= 7; j++) begin
            repeat (19) begin
                cycb(1'b0, 1'b0, 1'b0);
                if (b.gen_load_en) loads_after++;
            end
            cycb(1'b0, 1'b0, 1'b1);
            chk($sformatf("b_adv%0d", j),   b.gen_adv,     1'b1);
            chk($sformatf("b_pulse%0d", j), b.epoch_pulse, (j % 3) == 0);
            cycb(1'b0, 1'b0, 1'b0);
            if (b.gen_load_en) loads_after++;
            chk($sformatf("b_epoch%0d", j), b.epoch_count, 8'(j / 3));
            chk($sformatf("b_idx%0d", j),   b.chip_idx,    14'(j % 3));
        end
        chk("b_no_reload", loads_after, 0);
        chk("b_busy",      b.busy,      1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
